mem_responder: RTL and testbench

Synthesizable memory responder for the `instruction_set_model` CPU: the slave end of its data port (`MEM_ADDR`/`MEM_OUT`/`MEM_CTRL` → `MEM_IN`) and its instruction port (`INS_ADDR` → `INS_MEM`). It replaces the zero-delay behavioural memory with a clocked data memory that serves requests through a wait-state handshake, and a registered instruction memory. It also has a program-load port and a halt-triggered dump sequencer that streams the first words of data memory out for checking.

---
 rtl/mem_resp_pkg.sv | 23 ++
 rtl/mem_array.sv | 39 +++
 rtl/mem_responder.sv | 179 +++++++++++++++++
 tb/tb_mem_responder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: FSM encoding, default
// geometry and the wait-state counter width.
package mem_resp_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_ADDRSIZE = 12;
  localparam int WAIT_CNT_W   = 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_RESP = 3'd2;
  localparam logic [2:0] ST_DUMP = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_WAIT = ST_WAIT,
    S_RESP = ST_RESP,
    S_DUMP = ST_DUMP,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/mem_array.sv
// WIDTH x 2**ADDRSIZE word memory: one synchronous write port, one registered
// read port (read-old-data on collision) and one combinational read port.
module mem_array #(
  parameter int WIDTH    = 32,
  parameter int ADDRSIZE = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [WIDTH-1:0]    wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [WIDTH-1:0]    rdata,
  input  logic [ADDRSIZE-1:0] caddr,
  output logic [WIDTH-1:0]    cdata
);

  localparam int MEMSIZE = 1 << ADDRSIZE;

  // Contents are deliberately never reset.
  logic [WIDTH-1:0] mem [0:MEMSIZE-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

  assign cdata = mem[caddr];

endmodule

// File: rtl/mem_responder.sv
// Clocked data/instruction memory slave for the CPU, with a program-load
// port and a halt-triggered dump of the first DUMP_WORDS data words.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ADDRSIZE    = DEF_ADDRSIZE,
  parameter int WAIT_STATES = 1,
  parameter int DUMP_WORDS  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MEM_REQ,
  input  logic [ADDRSIZE-1:0] MEM_ADDR,
  input  logic                MEM_CTRL,
  input  logic [WIDTH-1:0]    MEM_OUT,
  output logic [WIDTH-1:0]    MEM_IN,
  output logic                MEM_RDY,
  input  logic [ADDRSIZE-1:0] INS_ADDR,
  output logic [WIDTH-1:0]    INS_MEM,
  input  logic                load_en,
  input  logic                load_sel,
  input  logic [ADDRSIZE-1:0] load_addr,
  input  logic [WIDTH-1:0]    load_data,
  input  logic                halt,
  output logic                dump_valid,
  output logic [ADDRSIZE-1:0] dump_addr,
  output logic [WIDTH-1:0]    dump_data,
  input  logic                dump_ready,
  output logic                dump_done,
  output logic [2:0]          fsm_state
);

  localparam logic [ADDRSIZE-1:0] DUMP_LAST = ADDRSIZE'(DUMP_WORDS - 1);

  state_t                state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [ADDRSIZE-1:0]   req_addr;
  logic                  req_write;
  logic [WIDTH-1:0]      req_data;
  logic                  halt_pend;
  logic                  rdy;

  logic                  go_dump;
  logic                  do_load;
  logic                  accept;
  logic                  commit;

  logic                  d_we;
  logic [ADDRSIZE-1:0]   d_waddr;
  logic [WIDTH-1:0]      d_wdata;
  logic [WIDTH-1:0]      d_rdata;
  logic [WIDTH-1:0]      d_cdata;
  logic                  i_we;
  logic [WIDTH-1:0]      ins_cdata_unused;

  // Handshake: the CPU holds MEM_REQ and its fields stable until it sees
  // MEM_RDY; MEM_RDY is a one-cycle pulse with MEM_IN valid in that cycle.
  // Dump words transfer on every cycle where dump_valid && dump_ready.
  assign go_dump = (state == S_IDLE) && (halt || halt_pend);
  assign do_load = (state == S_IDLE) && !go_dump && load_en;
  assign accept  = (state == S_IDLE) && !go_dump && !load_en && MEM_REQ;
  assign commit  = (state == S_WAIT) && (cnt == '0);

  always_comb begin
    d_we    = (do_load && !load_sel) || (commit && req_write);
    d_waddr = req_addr;
    d_wdata = req_data;
    if (do_load) begin
      d_waddr = load_addr;
      d_wdata = load_data;
    end
  end

  assign i_we = do_load && load_sel;

  mem_array #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) u_data_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (d_we),
    .waddr (d_waddr),
    .wdata (d_wdata),
    .raddr (req_addr),
    .rdata (d_rdata),
    .caddr (dump_addr),
    .cdata (d_cdata)
  );

  mem_array #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) u_ins_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (i_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (INS_ADDR),
    .rdata (INS_MEM),
    .caddr (INS_ADDR),
    .cdata (ins_cdata_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_addr   <= '0;
      req_write  <= 1'b0;
      req_data   <= '0;
      halt_pend  <= 1'b0;
      rdy        <= 1'b0;
      dump_valid <= 1'b0;
      dump_addr  <= '0;
      dump_done  <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go_dump) begin
            halt_pend <= 1'b0;
            dump_addr <= '0;
            if (DUMP_WORDS == 0) begin
              state     <= S_DONE;
              dump_done <= 1'b1;
            end else begin
              state      <= S_DUMP;
              dump_valid <= 1'b1;
            end
          end else if (accept) begin
            req_addr  <= MEM_ADDR;
            req_write <= MEM_CTRL;
            req_data  <= MEM_OUT;
            cnt       <= WAIT_CNT_W'(WAIT_STATES);
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (halt) begin
            halt_pend <= 1'b1;
          end
          // The write (if any) lands in the array on the edge entering RESP.
          if (cnt == '0) begin
            state <= S_RESP;
            rdy   <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (halt) begin
            halt_pend <= 1'b1;
          end
          state <= S_IDLE;
        end
        S_DUMP: begin
          if (dump_ready) begin
            if (dump_addr == DUMP_LAST) begin
              state      <= S_DONE;
              dump_valid <= 1'b0;
              dump_done  <= 1'b1;
            end else begin
              dump_addr <= dump_addr + 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign MEM_RDY   = rdy;
  assign MEM_IN    = rdy ? (req_write ? req_data : d_rdata) : '0;
  assign dump_data = dump_valid ? d_cdata : '0;
  assign fsm_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: expected data responses and dump words
// are queued at issue time and checked by independent monitors.
module tb_mem_responder;
  import mem_resp_pkg::*;

  localparam int W  = 32;
  localparam int AW = 12;
  localparam int WS = 1;
  localparam int DW = 10;

  logic          clk;
  logic          rst;
  logic          MEM_REQ;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_CTRL;
  logic [W-1:0]  MEM_OUT;
  logic [W-1:0]  MEM_IN;
  logic          MEM_RDY;
  logic [AW-1:0] INS_ADDR;
  logic [W-1:0]  INS_MEM;
  logic          load_en;
  logic          load_sel;
  logic [AW-1:0] load_addr;
  logic [W-1:0]  load_data;
  logic          halt;
  logic          dump_valid;
  logic [AW-1:0] dump_addr;
  logic [W-1:0]  dump_data;
  logic          dump_ready;
  logic          dump_done;
  logic [2:0]    fsm_state;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rdy_cnt = 0;

  logic [W-1:0]  exp_q[$];
  int            exp_cyc_q[$];
  logic [AW-1:0] dump_addr_q[$];
  logic [W-1:0]  dump_data_q[$];
  logic [W-1:0]  model[0:DW-1];

  mem_responder #(.WIDTH(W), .ADDRSIZE(AW), .WAIT_STATES(WS), .DUMP_WORDS(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .MEM_REQ    (MEM_REQ),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_CTRL   (MEM_CTRL),
    .MEM_OUT    (MEM_OUT),
    .MEM_IN     (MEM_IN),
    .MEM_RDY    (MEM_RDY),
    .INS_ADDR   (INS_ADDR),
    .INS_MEM    (INS_MEM),
    .load_en    (load_en),
    .load_sel   (load_sel),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .halt       (halt),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_ready (dump_ready),
    .dump_done  (dump_done),
    .fsm_state  (fsm_state)
  );

  // Clock / reset-independent cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_mem_rdy"}, 64'(MEM_RDY), 64'd0);
    check({tag, "_mem_in"}, 64'(MEM_IN), 64'd0);
    check({tag, "_ins_mem"}, 64'(INS_MEM), 64'd0);
    check({tag, "_dump_valid"}, 64'(dump_valid), 64'd0);
    check({tag, "_dump_addr"}, 64'(dump_addr), 64'd0);
    check({tag, "_dump_data"}, 64'(dump_data), 64'd0);
    check({tag, "_dump_done"}, 64'(dump_done), 64'd0);
    check({tag, "_state"}, 64'(fsm_state), 64'(ST_IDLE));
  endtask

  // Monitor: data responses.
  always @(negedge clk) begin
    if (rst && MEM_RDY) begin
      rdy_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_rdy", 64'd1, 64'd0);
      end else begin
        check("mem_in", 64'(MEM_IN), 64'(exp_q.pop_front()));
        check("rdy_cycle", 64'(cyc), 64'(exp_cyc_q.pop_front()));
      end
    end
  end

  // Monitor: dump stream.
  always @(negedge clk) begin
    if (rst && dump_valid && dump_ready) begin
      if (dump_addr_q.size() == 0) begin
        check("unexpected_dump", 64'd1, 64'd0);
      end else begin
        check("dump_addr", 64'(dump_addr), 64'(dump_addr_q.pop_front()));
        check("dump_data", 64'(dump_data), 64'(dump_data_q.pop_front()));
      end
    end
  end

  // Driver tasks: all are entered just after a rising edge.
  task automatic load(input logic sel, input logic [AW-1:0] addr, input logic [W-1:0] data);
    load_en = 1'b1; load_sel = sel; load_addr = addr; load_data = data;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic issue_req(input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] data,
                           input logic [W-1:0] exp, input int extra);
    exp_q.push_back(exp);
    exp_cyc_q.push_back(cyc + 2 + WS + extra);
    MEM_REQ = 1'b1; MEM_CTRL = wr; MEM_ADDR = addr; MEM_OUT = data;
  endtask

  task automatic wait_rdy();
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      load_en = 1'b0;
      n++;
    end while (!MEM_RDY && n < 50);
    if (!MEM_RDY) check("rdy_timeout", 64'd0, 64'd1);
    MEM_REQ = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic access(input logic wr, input logic [AW-1:0] addr, input logic [W-1:0] data,
                        input logic [W-1:0] exp, input int extra);
    issue_req(wr, addr, data, exp, extra);
    wait_rdy();
  endtask

  initial begin
    int n;
    int r0;
    rst = 1'b0; MEM_REQ = 1'b0; MEM_ADDR = '0; MEM_CTRL = 1'b0; MEM_OUT = '0;
    INS_ADDR = '0; load_en = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0;
    halt = 1'b0; dump_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    // Load then read, then write and read back immediately.
    load(1'b0, 12'd3, 32'd77);
    access(1'b0, 12'd3, '0, 32'd77, 0);
    access(1'b1, 12'd9, 32'd1234, 32'd1234, 0);
    access(1'b0, 12'd9, '0, 32'd1234, 0);

    // Instruction port follows INS_ADDR one cycle late.
    load(1'b1, 12'd0, 32'hA000_0000);
    load(1'b1, 12'd1, 32'hA000_0011);
    load(1'b1, 12'd2, 32'hA000_0022);
    for (int i = 0; i < 3; i++) begin
      INS_ADDR = AW'(i);
      @(posedge clk); #1;
      check("ins_sweep", 64'(INS_MEM), 64'(32'hA000_0000 + 32'(i) * 32'h11));
    end
    INS_ADDR = 12'd5;
    load(1'b1, 12'd5, 32'h0000_0ABC);
    @(posedge clk); #1;
    check("ins_load_visible", 64'(INS_MEM), 64'h0ABC);

    // Load and request in the same cycle: load wins, request accepted next cycle.
    load_en = 1'b1; load_sel = 1'b0; load_addr = 12'd20; load_data = 32'd500;
    access(1'b0, 12'd20, '0, 32'd500, 1);

    // Reset in the middle of a write drops it.
    access(1'b1, 12'd4, 32'd11, 32'd11, 0);
    MEM_REQ = 1'b1; MEM_CTRL = 1'b1; MEM_ADDR = 12'd4; MEM_OUT = 32'd55;
    @(posedge clk); #1;
    check("accept_to_wait", 64'(fsm_state), 64'(ST_WAIT));
    rst = 1'b0;
    #1;
    check_zero_outputs("midreset");
    MEM_REQ = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    access(1'b0, 12'd4, '0, 32'd11, 0);

    // Fill the dump window.
    for (int i = 0; i < DW; i++) begin
      model[i] = 32'h100 + 32'(i) * 32'd17;
      load(1'b0, AW'(i), model[i]);
    end
    for (int i = 0; i < DW; i++) begin
      dump_addr_q.push_back(AW'(i));
      dump_data_q.push_back(model[i]);
    end

    // Halt pulse during WAIT: read completes, then dump runs.
    issue_req(1'b0, 12'd2, '0, model[2], 0);
    @(posedge clk); #1;
    halt = 1'b1;
    @(posedge clk); #1;
    halt = 1'b0;
    wait_rdy();
    n = 0;
    dump_ready = 1'b1;
    while (!dump_done && n < 100) begin
      @(posedge clk); #1;
      dump_ready = ~dump_ready;
      n++;
    end
    dump_ready = 1'b0;
    check("dump_finished", 64'(dump_done), 64'd1);
    check("dump_words_left", 64'(dump_addr_q.size()), 64'd0);
    check("done_valid_low", 64'(dump_valid), 64'd0);
    check("done_state", 64'(fsm_state), 64'(ST_DONE));

    // DONE ignores requests and stays put.
    r0 = rdy_cnt;
    MEM_REQ = 1'b1; MEM_CTRL = 1'b0; MEM_ADDR = 12'd0;
    repeat (10) @(posedge clk);
    #1;
    MEM_REQ = 1'b0;
    check("done_no_rdy", 64'(rdy_cnt - r0), 64'd0);
    check("done_sticky", 64'(dump_done), 64'd1);
    check("resp_left", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
